fpu_share_ctrl: RTL and testbench

Arbiter and sequencer that shares one `fpu_simple` add/sub unit between `NUM_REQ` independent requesters. It accepts one operation at a time over a valid/ready handshake and selects among requesters round-robin. It drives the FPU operand ports, waits the FPU's fixed latency, captures result and status, and returns them to the granted requester over a held valid/ready response channel. It sits between the FPU and its client blocks, with the FPU instantiated alongside it at the same level.

---
 rtl/fpu_share_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fpu_share_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_ctrl.sv
// Round-robin arbiter and sequencer that shares one fixed-latency fpu_simple add/sub unit
// between NUM_REQ requesters; results return on a held, per-requester valid/ready channel.
module fpu_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int FPU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_op_a,
  input  logic [32*NUM_REQ-1:0]  req_op_b,
  input  logic [NUM_REQ-1:0]     req_op_sel,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [3:0]             rsp_status,
  output logic [31:0]            fpu_op_a,
  output logic [31:0]            fpu_op_b,
  output logic                   fpu_op_sel,
  input  logic [31:0]            fpu_data,
  input  logic [3:0]             fpu_status,
  output logic                   busy,
  output logic [15:0]            ops_done,
  output logic [1:0]             dbg_state
);

  // Handshakes: a transfer happens at the rising edge where valid && ready; a requester
  // holds valid (and its payload) until that edge, and ready never depends on valid falling.

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [3:0] LAT_LAST = 4'(FPU_LAT);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [IDW-1:0]    grant_q, grant_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic              op_sel_q, op_sel_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [3:0]        rsp_status_q, rsp_status_d;
  logic [15:0]       ops_done_q, ops_done_d;

  logic              win_found;
  logic [IDW-1:0]    win_id;
  logic [IDW:0]      cand;
  logic [NUM_REQ-1:0] win_oh, grant_oh;
  logic [31:0]       win_a, win_b;
  logic              win_sel;

  // Search starts one past the last grant and wraps, giving round-robin fairness.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] && (cand == (IDW+1)'(i))) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    win_oh   = '0;
    grant_oh = '0;
    win_a    = '0;
    win_b    = '0;
    win_sel  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_oh[i] = 1'b1;
        win_a     = req_op_a[32*i +: 32];
        win_b     = req_op_b[32*i +: 32];
        win_sel   = req_op_sel[i];
      end
      if (grant_q == IDW'(i)) grant_oh[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    ops_done_d   = ops_done_q;
    req_ready    = '0;
    rsp_valid    = '0;
    case (state_q)
      S_IDLE: begin
        // Ready is masked while reset is held so no request is accepted and then lost.
        if (win_found && !reset) begin
          req_ready    = win_oh;
          op_a_d       = win_a;
          op_b_d       = win_b;
          op_sel_d     = win_sel;
          grant_d      = win_id;
          last_grant_d = win_id;
          lat_cnt_d    = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == LAT_LAST) begin
          rsp_data_d   = fpu_data;
          rsp_status_d = fpu_status;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = grant_oh;
        if (|(rsp_ready & grant_oh)) begin
          if (ops_done_q != 16'hFFFF) ops_done_d = ops_done_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_RST;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign fpu_op_a   = op_a_q;
  assign fpu_op_b   = op_b_q;
  assign fpu_op_sel = op_sel_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign busy       = (state_q != S_IDLE);
  assign ops_done   = ops_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Bench for fpu_share_ctrl: a stand-in FPU with the plan's known vectors, a transaction-level
// reference model checked every cycle, directed scenarios and a randomized run.
module tb_fpu_share_ctrl;

  localparam int N   = 3;
  localparam int LAT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready, req_op_sel, rsp_valid, rsp_ready;
  logic [32*N-1:0]   req_op_a, req_op_b;
  logic [31:0]       rsp_data, fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]        rsp_status, fpu_status;
  logic              fpu_op_sel, busy;
  logic [15:0]       ops_done;
  logic [1:0]        dbg_state;

  fpu_share_ctrl #(.NUM_REQ(N), .FPU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_op_sel(req_op_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_op_sel(fpu_op_sel),
    .fpu_data(fpu_data), .fpu_status(fpu_status),
    .busy(busy), .ops_done(ops_done), .dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;

  // Stand-in for fpu_simple: exact results for the plan's vectors, a deterministic mix otherwise.
  function automatic logic [35:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] r;
    case ({s, a, b})
      {1'b0, 32'h3F800000, 32'h3F800000}: return {4'b0001, 32'h40000000};
      {1'b1, 32'h4D5D1148, 32'h4D5D1148}: return {4'b0001, 32'h00000000};
      {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF}: return {4'b1010, 32'h7F800000};
      default: begin
        r = s ? (a - b) : (a + b);
        return {r[3:0] ^ a[31:28], r};
      end
    endcase
  endfunction

  logic [35:0] fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_ref(fpu_op_a, fpu_op_b, fpu_op_sel);
    for (int k = 1; k < LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign {fpu_status, fpu_data} = fpu_pipe[LAT-1];

  // Reference model: one operation in flight, timed in cycles since its handshake.
  bit          m_active;
  int          m_t, m_gid, m_last;
  logic [15:0] m_ops;
  logic [31:0] m_data, m_a, m_b;
  logic [3:0]  m_status;
  logic        m_sel;
  logic [N-1:0] m_hs, m_rsp_hs;
  logic [35:0] exp_q[$];
  bit          ops_force_on = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_t = 0; m_gid = 0; m_last = N - 1;
    m_ops = '0; m_data = '0; m_status = '0; m_a = '0; m_b = '0; m_sel = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int win;
    logic [N-1:0] e_rdy, e_vld;
    logic [35:0] r;
    if (ops_force_on) m_ops = 16'hFFFD;
    win = -1; e_rdy = '0; e_vld = '0;
    if (!m_active && !reset)
      for (int k = 1; k <= N; k++)
        if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
    if (win >= 0) e_rdy[win] = 1'b1;
    if (m_active && m_t >= LAT + 2) e_vld[m_gid] = 1'b1;
    check("req_ready", req_ready, e_rdy);
    check("rsp_valid", rsp_valid, e_vld);
    check("rsp_data", rsp_data, m_data);
    check("rsp_status", rsp_status, m_status);
    check("fpu_op_a", fpu_op_a, m_a);
    check("fpu_op_b", fpu_op_b, m_b);
    check("fpu_op_sel", fpu_op_sel, m_sel);
    check("busy", busy, m_active);
    check("ops_done", ops_done, m_ops);
    check("dbg_state_active", dbg_state != 2'd0, m_active);
    m_hs = e_rdy & req_valid;
    m_rsp_hs = e_vld & rsp_ready;
    if (win >= 0)
      exp_q.push_back(fpu_ref(req_op_a[32*win +: 32], req_op_b[32*win +: 32], req_op_sel[win]));
    if (!reset && m_rsp_hs != '0) begin
      if (exp_q.size() == 0) check("sb_nonempty", 1'b0, 1'b1);
      else begin
        r = exp_q.pop_front();
        check("sb_rsp", {rsp_status, rsp_data}, r);
      end
    end
    if (reset) model_reset();
    else if (!m_active) begin
      if (win >= 0) begin
        m_active = 1'b1; m_t = 1; m_gid = win; m_last = win;
        m_a = req_op_a[32*win +: 32]; m_b = req_op_b[32*win +: 32]; m_sel = req_op_sel[win];
      end
    end else if (m_t < LAT + 2) begin
      m_t++;
      if (m_t == LAT + 2) {m_status, m_data} = fpu_ref(m_a, m_b, m_sel);
    end else if (rsp_ready[m_gid]) begin
      m_active = 1'b0;
      if (m_ops != 16'hFFFF) m_ops++;
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    req_valid[i] = 1'b1;
    req_op_a[32*i +: 32] = a;
    req_op_b[32*i +: 32] = b;
    req_op_sel[i] = s;
  endtask

  task automatic rand_op(input int i);
    case ($urandom_range(0, 7))
      0: set_req(i, 32'h3F800000, 32'h3F800000, 1'b0);
      1: set_req(i, 32'h4D5D1148, 32'h4D5D1148, 1'b1);
      2: set_req(i, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
      default: set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endcase
  endtask

  task automatic do_reset();
    go(); reset = 1'b1; req_valid = '0; tick();
    go(); reset = 1'b0; tick();
  endtask

  task automatic drain();
    bit idle_seen;
    idle_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      go(); req_valid = '0; rsp_ready = '1; tick();
      if (!m_active) begin idle_seen = 1'b1; break; end
    end
    check("drain_timeout", idle_seen, 1'b1);
  endtask

  task automatic wait_rsp();
    bit found;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      go(); req_valid = '0; tick();
      if (rsp_valid != '0) begin found = 1'b1; break; end
    end
    check("rsp_timeout", found, 1'b1);
  endtask

  task automatic rand_run(input int n, input bit rst_ok);
    for (int c = 0; c < n; c++) begin
      go();
      reset = rst_ok && ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_hs[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          if (req_valid[i]) rand_op(i);
        end
      end
      rsp_ready = N'($urandom);
      tick();
    end
    go(); reset = 1'b0; tick();
  endtask

  int grants[3];
  int n_g;
  bit got;
  logic [31:0] a0, b0;
  logic [35:0] e0;

  initial begin
    reset = 1'b1; req_valid = '0; req_op_a = '0; req_op_b = '0; req_op_sel = '0; rsp_ready = '0;
    model_reset();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_ops_done", ops_done, 16'h0);
    check("rst_rsp_valid", rsp_valid, 3'b000);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_fpu_op_a", fpu_op_a, 32'h0);

    // Single request: 1.0 + 1.0
    go(); reset = 1'b0; rsp_ready = '1; tick();
    go(); set_req(0, 32'h3F800000, 32'h3F800000, 1'b0); tick();
    check("t1_ready_c0", req_ready, 3'b001);
    go(); req_valid = '0; tick();
    go(); tick();
    go(); tick();
    check("t1_rsp_valid_c3", rsp_valid, 3'b001);
    check("t1_rsp_data", rsp_data, 32'h40000000);
    check("t1_exact", rsp_status[0], 1'b1);
    go(); tick();
    check("t1_ops_done", ops_done, 16'd1);
    check("t1_busy_low", busy, 1'b0);

    // Simultaneous requests from reset
    do_reset();
    go();
    set_req(0, $urandom, $urandom, 1'b0);
    set_req(1, 32'h4D5D1148, 32'h4D5D1148, 1'b1);
    rsp_ready = '1;
    tick();
    n_g = 0;
    for (int c = 0; c < 40; c++) begin
      check("t2_ready_onehot", $countones(req_ready) <= 1, 1'b1);
      for (int i = 0; i < N; i++) if (req_ready[i] && n_g < 3) begin grants[n_g] = i; n_g++; end
      if (rsp_valid == 3'b010) check("t2_req1_data", rsp_data, 32'h0);
      if (n_g >= 3) break;
      go(); tick();
    end
    check("t2_grant_count", n_g, 3);
    check("t2_grant0", grants[0], 0);
    check("t2_grant1", grants[1], 1);
    check("t2_grant2", grants[2], 0);
    drain();

    // Response backpressure
    do_reset();
    a0 = $urandom; b0 = $urandom; e0 = fpu_ref(a0, b0, 1'b0);
    go(); set_req(0, a0, b0, 1'b0); rsp_ready = '0; tick();
    go(); req_valid[0] = 1'b0; set_req(1, $urandom, $urandom, 1'b1); tick();
    go(); tick();
    go(); tick();
    check("t3_rsp_valid", rsp_valid, 3'b001);
    for (int c = 0; c < 5; c++) begin
      go(); tick();
      check("t3_hold_valid", rsp_valid, 3'b001);
      check("t3_hold_data", rsp_data, e0[31:0]);
      check("t3_hold_status", rsp_status, e0[35:32]);
      check("t3_ready_zero", req_ready, 3'b000);
    end
    go(); rsp_ready[0] = 1'b1; tick();
    go(); rsp_ready = '0; tick();
    check("t3_idle_busy", busy, 1'b0);
    check("t3_idle_grant1", req_ready, 3'b010);
    drain();

    // Overflow status pass-through on requester 1
    go(); set_req(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0); rsp_ready = '1; tick();
    wait_rsp();
    check("t4_rsp_valid", rsp_valid, 3'b010);
    check("t4_overflow", rsp_status[1], 1'b1);
    check("t4_status", rsp_status, 4'b1010);
    check("t4_data", rsp_data, 32'h7F800000);
    drain();

    // Reset in cycle 2 of a WAIT
    do_reset();
    go(); set_req(0, $urandom, $urandom, 1'b0); rsp_ready = '1; tick();
    go(); set_req(0, $urandom, $urandom, 1'b1); set_req(1, $urandom, $urandom, 1'b0); tick();
    go(); reset = 1'b1; tick();
    go(); reset = 1'b0; tick();
    check("t5_rsp_valid", rsp_valid, 3'b000);
    check("t5_busy", busy, 1'b0);
    check("t5_ops_done", ops_done, 16'h0);
    check("t5_rsp_data", rsp_data, 32'h0);
    check("t5_fpu_op_a", fpu_op_a, 32'h0);
    check("t5_req0_first", req_ready, 3'b001);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      go(); if (c == 0) req_valid[0] = 1'b0; tick();
      if (req_ready != '0) begin check("t5_next_grant", req_ready, 3'b010); got = 1'b1; break; end
    end
    check("t5_next_grant_seen", got, 1'b1);
    drain();

    rand_run(1200, 1'b1);
    drain();

    // Saturation: preload the counter just below the top, then keep completing
    go(); force dut.ops_done_q = 16'hFFFD; ops_force_on = 1'b1; tick();
    check("t6_forced", ops_done, 16'hFFFD);
    go(); release dut.ops_done_q; ops_force_on = 1'b0; tick();
    rand_run(300, 1'b0);
    drain();
    check("t6_saturated", ops_done, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
